// File: rtl/core_types_pkg.sv
// Shared core types: free-list, checkpoint and register-tag widths.
// Default sizes for the rename free list and the checkpoint columns live here
// so the free list and the map table agree on tag and column widths.
package core_types_pkg;

    localparam int FL_DEPTH     = 64;  // free list storage entries (power of two)
    localparam int TAG_WIDTH    = 6;   // physical register tag width
    localparam int NUM_COLS     = 4;   // checkpoint columns (power of two)
    localparam int INIT_FREE    = 32;  // physical minus architectural registers
    localparam int FL_PTR_WIDTH = $clog2(FL_DEPTH) + 1;
    localparam int COL_WIDTH    = $clog2(NUM_COLS);

    typedef logic [TAG_WIDTH-1:0]    phys_reg_tag_t;
    typedef logic [COL_WIDTH-1:0]    checkpoint_column_t;
    // Free list pointer: index bits plus one wrap bit for full/empty detection.
    typedef logic [FL_PTR_WIDTH-1:0] free_list_ptr_t;

endpackage

// File: rtl/ckpt_column_alloc.sv
// Checkpoint column allocator: circular allocation of checkpoint columns with
// oldest-first release and restore-to-column rollback. Holds only pointers, so
// the map table can reuse it alongside its own per-column storage.
module ckpt_column_alloc #(
    parameter  int NUM_COLS = core_types_pkg::NUM_COLS,
    localparam int COL_W    = $clog2(NUM_COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save_valid,
    input  logic             restore_valid,
    input  logic [COL_W-1:0] restore_column,
    input  logic             clear_valid,
    input  logic [COL_W-1:0] clear_column,
    output logic             save_ready,
    output logic [COL_W-1:0] save_column,
    output logic             save_fire,
    output logic             clear_error
);

    logic [COL_W-1:0] alloc_reg, alloc_next;
    logic [COL_W-1:0] oldest_reg, oldest_next;
    logic [COL_W:0]   num_reg, num_next;
    logic             clear_hit;
    logic             clear_ok;

    assign save_ready  = num_reg < (COL_W+1)'(NUM_COLS);
    assign save_column = alloc_reg;
    // A restore rewinds allocation, so a same-cycle save is dropped.
    assign save_fire   = save_valid && save_ready && !restore_valid;
    // Restore wins when both target the same column; the clear is then moot.
    assign clear_hit   = clear_valid && !(restore_valid && (restore_column == clear_column));
    assign clear_ok    = clear_hit && (num_reg != '0) && (clear_column == oldest_reg);
    assign clear_error = clear_hit && !clear_ok;

    // Next-state for the allocation window [oldest, oldest+num).
    always_comb begin
        alloc_next  = alloc_reg;
        oldest_next = oldest_reg;
        num_next    = num_reg;
        if (restore_valid) begin
            // Drop the restored column and everything younger than it.
            alloc_next = restore_column;
            num_next   = {1'b0, restore_column - oldest_reg};
        end else if (save_fire) begin
            alloc_next = alloc_reg + 1'b1;
            num_next   = num_reg + 1'b1;
        end
        if (clear_ok) begin
            oldest_next = oldest_reg + 1'b1;
            num_next    = num_next - 1'b1;
        end
    end

    // Allocation pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_reg  <= '0;
            oldest_reg <= '0;
            num_reg    <= '0;
        end else begin
            alloc_reg  <= alloc_next;
            oldest_reg <= oldest_next;
            num_reg    <= num_next;
        end
    end

endmodule

// File: rtl/phys_reg_free_list_ckpt.sv
// Physical register free list with branch checkpoints.
// Circular tag buffer; head is checkpointed per branch column and rolled back
// on a mispredict, tail (commit side) is never rolled back.
// Optional feature macro FREE_LIST_BYPASS_EN: when the list is empty, an
// incoming enq_tag is forwarded straight to deq_tag.
module phys_reg_free_list_ckpt #(
    parameter  int FL_DEPTH  = core_types_pkg::FL_DEPTH,
    parameter  int TAG_WIDTH = core_types_pkg::TAG_WIDTH,
    parameter  int NUM_COLS  = core_types_pkg::NUM_COLS,
    parameter  int INIT_FREE = core_types_pkg::INIT_FREE,
    localparam int IDX_W     = $clog2(FL_DEPTH),
    localparam int PTR_W     = IDX_W + 1,
    localparam int COL_W     = $clog2(NUM_COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 deq_ready,
    output logic                 deq_valid,
    output logic [TAG_WIDTH-1:0] deq_tag,
    input  logic                 enq_valid,
    input  logic [TAG_WIDTH-1:0] enq_tag,
    input  logic                 save_valid,
    output logic                 save_ready,
    output logic [COL_W-1:0]     save_column,
    input  logic                 restore_valid,
    input  logic [COL_W-1:0]     restore_column,
    input  logic                 clear_valid,
    input  logic [COL_W-1:0]     clear_column,
    output logic [PTR_W-1:0]     count,
    output logic                 overflow
);

    logic [TAG_WIDTH-1:0] mem_reg [FL_DEPTH];
    logic [PTR_W-1:0]     ckpt_head_reg [NUM_COLS];
    logic [PTR_W-1:0]     head_reg, head_next, head_after_deq;
    logic [PTR_W-1:0]     tail_reg, tail_next;
    logic                 overflow_reg;
    logic                 empty, full, bypass;
    logic                 deq_pop, bypass_take, enq_write, enq_drop;
    logic                 save_fire, clear_error;

    assign empty = (head_reg == tail_reg);
    assign full  = (head_reg[IDX_W] != tail_reg[IDX_W]) &&
                   (head_reg[IDX_W-1:0] == tail_reg[IDX_W-1:0]);

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = empty && enq_valid;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid = !empty || bypass;
    assign deq_tag   = bypass ? enq_tag : mem_reg[head_reg[IDX_W-1:0]];

    // A restore overrides rename-side activity; commit-side enqueue still lands.
    assign deq_pop     = !empty && deq_ready && !restore_valid;
    assign bypass_take = bypass && deq_ready && !restore_valid;
    assign enq_write   = enq_valid && !full && !bypass_take;
    assign enq_drop    = enq_valid && full;

    assign head_after_deq = head_reg + PTR_W'(deq_pop);
    assign head_next      = restore_valid ? ckpt_head_reg[restore_column] : head_after_deq;
    assign tail_next      = tail_reg + PTR_W'(enq_write);
    assign count          = tail_reg - head_reg;
    assign overflow       = overflow_reg;

    ckpt_column_alloc #(
        .NUM_COLS (NUM_COLS)
    ) u_col_alloc (
        .clk            (clk),
        .rst            (rst),
        .save_valid     (save_valid),
        .restore_valid  (restore_valid),
        .restore_column (restore_column),
        .clear_valid    (clear_valid),
        .clear_column   (clear_column),
        .save_ready     (save_ready),
        .save_column    (save_column),
        .save_fire      (save_fire),
        .clear_error    (clear_error)
    );

    // Tag storage: preloaded with the initially free tags, written at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_reg[i] <= (i < INIT_FREE) ? TAG_WIDTH'(FL_DEPTH - INIT_FREE + i) : '0;
            end
        end else if (enq_write) begin
            mem_reg[tail_reg[IDX_W-1:0]] <= enq_tag;
        end
    end

    // Checkpointed head per column, captured after this cycle's dequeue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                ckpt_head_reg[c] <= '0;
            end
        end else if (save_fire) begin
            ckpt_head_reg[save_column] <= head_after_deq;
        end
    end

    // Head/tail pointers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= PTR_W'(INIT_FREE);
            overflow_reg <= 1'b0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            if (enq_drop || clear_error) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Bench for phys_reg_free_list_ckpt: directed stimulus, a queue-based model of
// the free list and checkpoint columns, a per-cycle compare process, and
// hand-computed literal expectations at key points.
module tb_phys_reg_free_list_ckpt;

    localparam int FL_DEPTH = 64;
    localparam int TAG_W    = 6;
    localparam int NCOL     = 4;
    localparam int INIT     = 32;
`ifdef FREE_LIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             deq_ready;
    logic             deq_valid;
    logic [TAG_W-1:0] deq_tag;
    logic             enq_valid;
    logic [TAG_W-1:0] enq_tag;
    logic             save_valid;
    logic             save_ready;
    logic [1:0]       save_column;
    logic             restore_valid;
    logic [1:0]       restore_column;
    logic             clear_valid;
    logic [1:0]       clear_column;
    logic [6:0]       count;
    logic             overflow;

    phys_reg_free_list_ckpt dut (
        .clk            (clk),
        .rst            (rst),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_tag        (deq_tag),
        .enq_valid      (enq_valid),
        .enq_tag        (enq_tag),
        .save_valid     (save_valid),
        .save_ready     (save_ready),
        .save_column    (save_column),
        .restore_valid  (restore_valid),
        .restore_column (restore_column),
        .clear_valid    (clear_valid),
        .clear_column   (clear_column),
        .count          (count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Every tag ever placed in the list, indexed by absolute position; the
    // list content is tag_log[m_deq .. m_enq-1].
    int tag_log [0:1023];
    int m_deq, m_enq;
    int ck_col [$];   // allocated columns, oldest first
    int ck_idx [$];   // saved absolute dequeue position per column
    int m_next_col;
    bit m_ovf;
    bit model_live = 1'b0;

    int mt_cnt, mt_p;
    bit mt_byp, mt_fire, mt_ready, mt_consumed;

    function automatic int m_count();
        return m_enq - m_deq;
    endfunction

    function automatic bit m_byp();
        return BYP && (m_count() == 0) && enq_valid;
    endfunction

    function automatic bit m_deq_valid();
        return (m_count() != 0) || m_byp();
    endfunction

    function automatic int m_deq_tag();
        return m_byp() ? int'(enq_tag) : tag_log[m_deq];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INIT; i++) tag_log[i] = FL_DEPTH - INIT + i;
            m_deq      = 0;
            m_enq      = INIT;
            ck_col.delete();
            ck_idx.delete();
            m_next_col = 0;
            m_ovf      = 1'b0;
            model_live = 1'b1;
        end else begin
            mt_cnt      = m_count();
            mt_byp      = m_byp();
            mt_fire     = m_deq_valid() && deq_ready;
            mt_ready    = ck_col.size() < NCOL;
            mt_consumed = 1'b0;
            if (restore_valid) begin
                mt_p = -1;
                for (int i = 0; i < ck_col.size(); i++)
                    if (ck_col[i] == int'(restore_column) && mt_p < 0) mt_p = i;
                if (mt_p >= 0) begin
                    m_deq = ck_idx[mt_p];
                    while (ck_col.size() > mt_p) begin
                        void'(ck_col.pop_back());
                        void'(ck_idx.pop_back());
                    end
                end
                m_next_col = int'(restore_column);
            end
            if (clear_valid && !(restore_valid && clear_column == restore_column)) begin
                if (ck_col.size() > 0 && ck_col[0] == int'(clear_column)) begin
                    void'(ck_col.pop_front());
                    void'(ck_idx.pop_front());
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (!restore_valid) begin
                if (save_valid && mt_ready) begin
                    ck_col.push_back(m_next_col);
                    ck_idx.push_back(m_deq + ((mt_fire && !mt_byp) ? 1 : 0));
                    m_next_col = (m_next_col + 1) % NCOL;
                end
                if (mt_fire) begin
                    if (mt_byp) mt_consumed = 1'b1;
                    else        m_deq++;
                end
            end
            if (enq_valid && !mt_consumed) begin
                if (mt_cnt == FL_DEPTH) m_ovf = 1'b1;
                else begin
                    tag_log[m_enq] = int'(enq_tag);
                    m_enq++;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!rst && model_live) begin
            check("deq_valid", int'(deq_valid), int'(m_deq_valid()));
            if (m_deq_valid()) check("deq_tag", int'(deq_tag), m_deq_tag());
            check("count", int'(count), m_count());
            check("save_ready", int'(save_ready), (ck_col.size() < NCOL) ? 1 : 0);
            check("save_column", int'(save_column), m_next_col);
            check("overflow", int'(overflow), int'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        deq_ready = 0; enq_valid = 0; enq_tag = '0; save_valid = 0;
        restore_valid = 0; restore_column = '0; clear_valid = 0; clear_column = '0;
    endtask

    task automatic drive(input bit dr, input bit ev, input int et, input bit sv,
                         input bit rv, input int rc, input bit cv, input int cc);
        deq_ready = dr; enq_valid = ev; enq_tag = et[TAG_W-1:0]; save_valid = sv;
        restore_valid = rv; restore_column = rc[1:0]; clear_valid = cv; clear_column = cc[1:0];
        $display("txn t=%0t deq=%0d enq=%0d/%0d save=%0d restore=%0d/%0d clear=%0d/%0d",
                 $time, dr, ev, et, sv, rv, rc, cv, cc);
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn t=%0t reset", $time);
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        do_reset();
        check("rst_deq_tag", int'(deq_tag), 32);
        check("rst_deq_valid", int'(deq_valid), 1);
        check("rst_count", int'(count), 32);
        check("rst_save_ready", int'(save_ready), 1);
        check("rst_save_column", int'(save_column), 0);
        check("rst_overflow", int'(overflow), 0);

        // Drain all 32, one extra dequeue on empty, then refill with tag 7.
        for (int i = 0; i < 32; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("drain_deq_valid", int'(deq_valid), 0);
        check("drain_count", int'(count), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("empty_deq_count", int'(count), 0);
        drive(0, 1, 7, 0, 0, 0, 0, 0);
        check("refill_deq_tag", int'(deq_tag), 7);
        check("refill_deq_valid", int'(deq_valid), 1);
        check("refill_count", int'(count), 1);

        // Checkpoint at head 3, five dequeues plus one enqueue, restore.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        check("ckpt_save_column", int'(save_column), 1);
        for (int i = 0; i < 5; i++) drive(1, (i == 2), 9, 0, 0, 0, 0, 0);
        check("ckpt_window_count", int'(count), 25);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("ckpt_restore_tag", int'(deq_tag), 35);
        check("ckpt_restore_count", int'(count), 30);
        check("ckpt_restore_column", int'(save_column), 0);

        // Column allocation: fill, clear oldest, restore, refill.
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
        check("cols_full_ready", int'(save_ready), 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        check("cols_full_column", int'(save_column), 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check("cols_clear_ready", int'(save_ready), 1);
        check("cols_clear_column", int'(save_column), 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        check("cols_restore_column", int'(save_column), 1);
        check("cols_restore_ready", int'(save_ready), 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0, 0);
        check("cols_three_ready", int'(save_ready), 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        check("cols_refull_ready", int'(save_ready), 0);
        drive(0, 0, 0, 0, 1, 1, 1, 1);
        check("rc_same_overflow", int'(overflow), 0);
        check("rc_same_column", int'(save_column), 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 2, 1, 1);
        check("rc_diff_column", int'(save_column), 2);
        check("rc_diff_overflow", int'(overflow), 0);
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        check("bad_clear_overflow", int'(overflow), 1);

        // Restore with same-cycle dequeue, enqueue and save.
        do_reset();
        check("rst2_overflow", int'(overflow), 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 1, 1, 0, 0, 0);
        check("sim_deq_tag", int'(deq_tag), 32);
        check("sim_count", int'(count), 33);
        check("sim_save_column", int'(save_column), 0);

        // Fill to capacity, drop one, then drain across the wrap.
        for (int i = 0; i < 31; i++) drive(0, 1, 10 + i, 0, 0, 0, 0, 0);
        check("full_count", int'(count), 64);
        drive(0, 1, 63, 0, 0, 0, 0, 0);
        check("full_drop_overflow", int'(overflow), 1);
        check("full_drop_count", int'(count), 64);
        for (int i = 0; i < 64; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_count", int'(count), 0);

        // Empty list with enqueue of tag 40 and a dequeue request.
        deq_ready = 1; enq_valid = 1; enq_tag = 6'd40;
        $display("txn t=%0t deq=1 enq=1/40 on empty list", $time);
        #1;
`ifdef FREE_LIST_BYPASS_EN
        check("byp_deq_valid", int'(deq_valid), 1);
        check("byp_deq_tag", int'(deq_tag), 40);
`else
        check("nobyp_deq_valid", int'(deq_valid), 0);
`endif
        @(posedge clk);
        #1;
        set_idle();
`ifdef FREE_LIST_BYPASS_EN
        check("byp_count", int'(count), 0);
`else
        check("nobyp_count", int'(count), 1);
        check("nobyp_deq_tag", int'(deq_tag), 40);
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list_ckpt.md
PHYS_REG_FREE_LIST_CKPT -- requirements
Module: phys_reg_free_list_ckpt

Interface
REQ-001 SHALL have parameter FL_DEPTH, default 64 (FREE_LIST_DEPTH): storage entries, power of two.
REQ-002 SHALL have parameter TAG_WIDTH, default 6 (PHYS_REG_WIDTH): phys reg tag width.
REQ-003 SHALL have parameter NUM_COLS, default 4 (CHECKPOINT_COLUMNS): checkpoint columns, power of two.
REQ-004 SHALL have parameter INIT_FREE, default 32 (NUM_PHYS_REGS - NUM_ARCH_REGS): tags free after reset.
REQ-005 SHALL use a single clock and a synchronous, active-high reset: CLK  in  1  clock; RST  in  1  synchronous active-high reset.
REQ-006 SHALL have deq_ready  in  1  rename requests a tag; deq_valid  out  1  tag available; deq_tag  out  TAG_WIDTH  head tag.
REQ-007 SHALL have enq_valid  in  1  commit frees a tag; enq_tag  in  TAG_WIDTH  tag freed.
REQ-008 SHALL have save_valid  in  1  checkpoint request; save_ready  out  1  free column exists; save_column  out  log2(NUM_COLS)  column to be allocated.
REQ-009 SHALL have restore_valid  in  1  mispredict restore; restore_column  in  log2(NUM_COLS)  column to restore.
REQ-010 SHALL have clear_valid  in  1  branch resolved correct; clear_column  in  log2(NUM_COLS)  oldest column to release.
REQ-011 SHALL have count  out  log2(FL_DEPTH)+1  free tags held; overflow  out  1  sticky error flag.

Function
REQ-012 SHALL hold tags in a circular buffer; head/tail pointers carry one extra msb; empty = (head==tail), full = msbs differ and low bits equal.
REQ-013 SHALL drive deq_valid = !empty and deq_tag = entry[head] combinationally; dequeue fires when deq_valid && deq_ready; head advances next cycle.
REQ-014 SHALL write enq_tag at tail and advance tail on enq_valid when not full; enq_valid while full SHALL be dropped and set overflow.
REQ-015 SHALL compute count = tail - head (extra-msb modulo arithmetic).
REQ-016 SHALL allocate checkpoint columns in circular order; save fires when save_valid && save_ready; the column stores the head value after this cycle's dequeue (if any).
REQ-017 SHALL drive save_ready = number of allocated columns < NUM_COLS.
REQ-018 SHALL on restore_valid set head to the restored column's saved head, deallocate that column and all younger columns, and set next save_column to restore_column.
REQ-019 SHALL on restore ignore same-cycle dequeue and save; same-cycle enqueue SHALL be honoured (tail never restored).
REQ-020 SHALL on clear_valid release the oldest column; clear_column not equal to oldest SHALL set overflow and be ignored.
REQ-021 SHALL apply restore with priority over clear when both target the same column; otherwise both take effect.
REQ-022 SHALL wrap pointers and column indices modulo depth without gaps.

Reset
REQ-023 SHALL on RST load entry[i] = INIT_FREE_BASE + i for i < INIT_FREE (base FL_DEPTH - INIT_FREE, i.e. tags 32..63), head = 0, tail = INIT_FREE, count = INIT_FREE.
REQ-024 SHALL on RST clear all columns (save_ready = 1, save_column = 0), clear overflow, and discard any in-flight request; RST mid-operation overrides all inputs.

Configuration
REQ-025 SHALL, with FREE_LIST_BYPASS_EN defined, forward enq_tag to deq_tag with deq_valid = 1 when empty and enq_valid is high; the tag is consumed without being written if dequeued that cycle.
REQ-026 SHALL, without FREE_LIST_BYPASS_EN, drive deq_valid = 0 whenever empty regardless of enq_valid.

Structure
REQ-027 SHALL take FL_DEPTH, TAG_WIDTH, NUM_COLS defaults and phys_reg_tag_t, checkpoint_column_t from core_types_pkg; add free_list_ptr_t (log2(FL_DEPTH)+1 bits) to that package.
REQ-028 SHALL keep checkpoint column allocation (alloc/restore/clear pointers) in one sub-module, ckpt_column_alloc, reusable by the map table.

Verification
REQ-029 SHALL cover reset: after RST, deq_tag = 32, count = 32, save_ready = 1, save_column = 0.
REQ-030 SHALL cover drain/refill: 32 dequeues -> deq_valid = 0, count = 0; enqueue 7 -> deq_tag = 7 next cycle.
REQ-031 SHALL cover checkpoint: save at head = 3, dequeue 5 tags, restore column 0 -> deq_tag = tag previously at head 3, count restored plus enqueues during window.
REQ-032 SHALL cover columns: 4 saves -> save_ready = 0; clear column 0 -> save_ready = 1, save_column = 0; restore column 1 frees 1..3.
REQ-033 SHALL cover simultaneous restore + dequeue + enqueue: head from column, tail advances by 1, dequeue ignored.
REQ-034 SHALL cover bypass: empty list, enq_valid with tag 40 and deq_ready -> deq_tag = 40 same cycle with macro, deq_valid = 0 without; count stays 0 with macro.
